// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM states, parity selectors
// and small bit-level helpers reused by RX logic and benches.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Frames narrower than this are zero-extended, which leaves the XOR unchanged.
   localparam int PAR_MAX_WIDTH = 32;

   function automatic logic parity_bit(input logic [PAR_MAX_WIDTH-1:0] data,
                                       input logic                     par_type);
      logic result;
      case (par_type)
         PAR_EVEN: result = ^data;
         PAR_ODD:  result = ~(^data);
         default:  result = ^data;
      endcase
      return result;
   endfunction

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter and 2-of-3 majority voter around the bit centre.
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic rx_s,
   input  logic count_en,
   output logic sample_done,
   output logic bit_val,
   output logic bit_end
);

   localparam int EW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [EW-1:0] SAMPLE_A = EW'(PRESCALE / 2 - 1);
   localparam logic [EW-1:0] SAMPLE_B = EW'(PRESCALE / 2);
   localparam logic [EW-1:0] SAMPLE_C = EW'(PRESCALE / 2 + 1);
   localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);

   logic [EW-1:0] edge_cnt_r;
   logic          samp_a_r;
   logic          samp_b_r;

   // Edge counter wraps each bit; it parks at zero whenever the FSM is not counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         edge_cnt_r <= '0;
         samp_a_r   <= 1'b1;
         samp_b_r   <= 1'b1;
      end else begin
         if (!count_en) begin
            edge_cnt_r <= '0;
         end else if (edge_cnt_r == EDGE_LAST) begin
            edge_cnt_r <= '0;
         end else begin
            edge_cnt_r <= edge_cnt_r + EW'(1);
         end
         if (count_en && (edge_cnt_r == SAMPLE_A)) begin
            samp_a_r <= rx_s;
         end
         if (count_en && (edge_cnt_r == SAMPLE_B)) begin
            samp_b_r <= rx_s;
         end
      end
   end

   // Third sample is the live line value, so the vote resolves on the decision cycle.
   assign sample_done = (edge_cnt_r == SAMPLE_C);
   assign bit_end     = (edge_cnt_r == EDGE_LAST);
   assign bit_val     = majority3(samp_a_r, samp_b_r, rx_s);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, shift register, parity/stop checks and
// registered one-cycle result pulses.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE   = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  Par_EN,
   input  logic                  Par_type,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_valid,
   output logic                  Parity_error,
   output logic                  Stop_error
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   logic [1:0]            sync_r;
   logic                  rx_s;
   rx_state_e             state_r;
   logic [BW-1:0]         bit_cnt_r;
   logic [DATA_WIDTH-1:0] shift_r;
   logic                  par_en_r;
   logic                  par_type_r;
   logic                  par_bad_r;
   logic [DATA_WIDTH-1:0] p_data_r;
   logic                  data_valid_r;
   logic                  parity_error_r;
   logic                  stop_error_r;
   logic                  count_en_s;
   logic                  sample_done_s;
   logic                  bit_val_s;
   logic                  bit_end_s;
   logic                  exp_par_s;

   // Two-flop synchronizer; resets to the idle line level.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], RX_IN};
      end
   end

   assign rx_s = sync_r[1];

   // Counting stops on the exact cycles the FSM falls back to IDLE, so the next
   // start edge always begins at edge zero.
   always_comb begin
      count_en_s = 1'b0;
      case (state_r)
         IDLE:    count_en_s = ~rx_s;
         START:   count_en_s = ~(sample_done_s & bit_val_s);
         DATA:    count_en_s = 1'b1;
         PARITY:  count_en_s = 1'b1;
         STOP:    count_en_s = ~sample_done_s;
         default: count_en_s = 1'b0;
      endcase
   end

   uart_rx_sampler #(
      .PRESCALE (PRESCALE)
   ) u_sampler (
      .clk         (CLK),
      .rst         (RST),
      .rx_s        (rx_s),
      .count_en    (count_en_s),
      .sample_done (sample_done_s),
      .bit_val     (bit_val_s),
      .bit_end     (bit_end_s)
   );

   assign exp_par_s = parity_bit(PAR_MAX_WIDTH'(shift_r), par_type_r);

   // Frame FSM with shift register, parity tracking and registered result pulses.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r        <= IDLE;
         bit_cnt_r      <= '0;
         shift_r        <= '0;
         par_en_r       <= 1'b0;
         par_type_r     <= 1'b0;
         par_bad_r      <= 1'b0;
         p_data_r       <= '0;
         data_valid_r   <= 1'b0;
         parity_error_r <= 1'b0;
         stop_error_r   <= 1'b0;
      end else begin
         data_valid_r   <= 1'b0;
         parity_error_r <= 1'b0;
         stop_error_r   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (!rx_s) begin
                  state_r    <= START;
                  par_en_r   <= Par_EN;
                  par_type_r <= Par_type;
                  par_bad_r  <= 1'b0;
                  bit_cnt_r  <= '0;
               end
            end
            START: begin
               if (sample_done_s && bit_val_s) begin
                  state_r <= IDLE;
               end else if (bit_end_s) begin
                  state_r <= DATA;
               end
            end
            DATA: begin
               if (sample_done_s) begin
                  shift_r <= {bit_val_s, shift_r[DATA_WIDTH-1:1]};
               end
               if (bit_end_s) begin
                  if (bit_cnt_r == LAST_BIT) begin
                     bit_cnt_r <= '0;
                     state_r   <= par_en_r ? PARITY : STOP;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + BW'(1);
                  end
               end
            end
            PARITY: begin
               if (sample_done_s && (bit_val_s != exp_par_s)) begin
                  par_bad_r <= 1'b1;
               end
               if (bit_end_s) begin
                  state_r <= STOP;
               end
            end
            STOP: begin
               // Leave at mid-bit so a back-to-back start edge is not missed.
               if (sample_done_s) begin
                  state_r <= IDLE;
                  if (!bit_val_s) begin
                     stop_error_r <= 1'b1;
                  end else if (par_bad_r) begin
                     parity_error_r <= 1'b1;
                  end else begin
                     p_data_r     <= shift_r;
                     data_valid_r <= 1'b1;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign P_DATA       = p_data_r;
   assign Data_valid   = data_valid_r;
   assign Parity_error = parity_error_r;
   assign Stop_error   = stop_error_r;

endmodule
